// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch/countdown timer.
// Pure definitions: no latency, no backpressure.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_UP0    = 2'd0;
    localparam logic [1:0] MODE_UP_PRE = 2'd1;
    localparam logic [1:0] MODE_DN_MAX = 2'd2;
    localparam logic [1:0] MODE_DN_PRE = 2'd3;

    // Active-low gfedcba patterns.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    function automatic logic [3:0] load_digit(input logic [1:0] mode, input logic [3:0] nib);
        logic [3:0] d;
        case (mode)
            MODE_UP0:                 d = 4'd0;
            MODE_DN_MAX:              d = 4'd9;
            MODE_UP_PRE, MODE_DN_PRE: d = (nib > 4'd9) ? 4'd9 : nib;
            default:                  d = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 blank.
// Zero latency, no backpressure.
module bcd_to_sseg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_timer_core.sv
// N-digit BCD stopwatch/countdown with lap freeze and multiplexed 7-seg drive.
// Button events act two cycles after the input edge; count same edge as count_tick; no backpressure.
module stopwatch_timer_core
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DP_POS     = 2,
    parameter int LEAD_BLANK = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      count_tick,
    input  logic                      scan_tick,
    input  logic                      stopstart,
    input  logic                      lap,
    input  logic [1:0]                modesel,
    input  logic [4*NUM_DIGITS-1:0]   preset,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                sseg,
    output logic                      done
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_LSB = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic                  ss_r, ss_prev, lap_r, lap_prev;
    logic [1:0]            mode_r, mode_q;
    logic [W-1:0]          cnt, cnt_step, snap, load_val, disp;
    logic                  frozen, frz_nxt, snap_en;
    logic                  do_count, do_load;
    logic [IW-1:0]         idx;
    logic [NUM_DIGITS-1:0] wrap, step_wrap, zero_d, blank;
    logic                  ss_ev, lap_ev, mode_chg, count_up, at_term, step_term;
    logic [3:0]            cur_bcd;
    logic [6:0]            seg_dec;

    assign ss_ev    = ss_r & ~ss_prev;
    assign lap_ev   = lap_r & ~lap_prev;
    assign mode_chg = (mode_r != mode_q);
    assign count_up = (mode_r == MODE_UP0) || (mode_r == MODE_UP_PRE);
    assign disp     = frozen ? snap : cnt;

    // wrap marks a digit at its terminal value for the current direction,
    // so the whole counter is terminal exactly when every digit wraps.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] d, s;
        logic       cin;
        assign d       = cnt[4*i +: 4];
        assign wrap[i] = count_up ? (d == 4'd9) : (d == 4'd0);
        if (i == 0) begin : g_lsd
            assign cin = 1'b1;
        end else begin : g_chain
            assign cin = &wrap[i-1:0];
        end
        assign s = !cin    ? d :
                   wrap[i] ? (count_up ? 4'd0 : 4'd9) :
                             (count_up ? d + 4'd1 : d - 4'd1);
        assign cnt_step[4*i +: 4] = s;
        assign step_wrap[i]       = count_up ? (s == 4'd9) : (s == 4'd0);
        assign load_val[4*i +: 4] = load_digit(mode_r, preset[4*i +: 4]);
        assign zero_d[i]          = (disp[4*i +: 4] == 4'd0);
        if (i == 0) begin : g_noblank
            assign blank[i] = 1'b0;
        end else begin : g_blank
            assign blank[i] = (LEAD_BLANK != 0) && (&zero_d[NUM_DIGITS-1:i]);
        end
    end

    assign at_term   = &wrap;
    assign step_term = &step_wrap;

    always_comb begin
        state_nxt = state;
        do_count  = 1'b0;
        do_load   = 1'b0;
        frz_nxt   = frozen;
        snap_en   = 1'b0;
        if (mode_chg) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    do_load   = 1'b1;
                    state_nxt = ST_ARMED;
                end
                ST_ARMED: if (ss_ev) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (ss_ev) begin
                        state_nxt = ST_PAUSE;
                    end else if (count_tick) begin
                        if (at_term) begin
                            state_nxt = ST_DONE;
                        end else begin
                            do_count = 1'b1;
                            if (step_term) state_nxt = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: if (ss_ev) state_nxt = ST_RUN;
                ST_DONE:  if (ss_ev) state_nxt = ST_LOAD;
                default:  state_nxt = ST_LOAD;
            endcase
        end
        if (lap_ev && (state == ST_RUN || state == ST_PAUSE)) begin
            frz_nxt = ~frozen;
            snap_en = ~frozen;
        end
        if (state == ST_LOAD || state_nxt == ST_LOAD || state_nxt == ST_DONE) frz_nxt = 1'b0;
    end

    always_comb begin
        cur_bcd = disp[4*idx +: 4];
        if (blank[idx]) cur_bcd = 4'hF;
    end

    bcd_to_sseg u_dec (
        .bcd (cur_bcd),
        .seg (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_LOAD;
            ss_r     <= 1'b0;
            ss_prev  <= 1'b0;
            lap_r    <= 1'b0;
            lap_prev <= 1'b0;
            mode_r   <= 2'd0;
            mode_q   <= 2'd0;
            cnt      <= '0;
            snap     <= '0;
            frozen   <= 1'b0;
            idx      <= '0;
            an       <= '1;
            sseg     <= 8'hFF;
        end else begin
            ss_r     <= stopstart;
            ss_prev  <= ss_r;
            lap_r    <= lap;
            lap_prev <= lap_r;
            mode_r   <= modesel;
            mode_q   <= mode_r;
            state    <= state_nxt;
            frozen   <= frz_nxt;
            if (snap_en) snap <= cnt;
            if (do_load)       cnt <= load_val;
            else if (do_count) cnt <= cnt_step;
            if (scan_tick) begin
                if (idx == IW'(NUM_DIGITS - 1)) idx <= '0;
                else                            idx <= idx + 1'b1;
            end
            an   <= ~(AN_LSB << idx);
            sseg <= {(int'(idx) == DP_POS) ? 1'b0 : 1'b1, seg_dec};
        end
    end

    assign done = (state == ST_DONE);

endmodule

// File: doc/stopwatch_timer_core.md
# stopwatch_timer_core

Parametrised N-digit BCD stopwatch/countdown timer with built-in multiplexed 7-segment drive. Next generation of the board-level timer: single clock with tick enables instead of multiple clocks, per-digit BCD counting instead of binary-plus-converter, and new lap-freeze, terminal-count and leading-zero-blanking behaviour. Sits between the debounced board buttons/switches and the anode/segment pins.

## Interface
- NUM_DIGITS, 4: number of BCD digits and anodes, 2..8.
- DP_POS, 2: digit index whose decimal point is lit; NUM_DIGITS disables it.
- LEAD_BLANK, 0: 1 blanks leading zero digits; the least-significant digit is never blanked.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; all state is cleared on the clk edge where it is high.
- count_tick  in  1  one-cycle count enable, nominally 100 Hz.
- scan_tick  in  1  one-cycle display-advance enable, nominally 1 kHz.
- stopstart  in  1  debounced level, synchronous to clk; its rising edge is the event.
- lap  in  1  debounced level, synchronous to clk; its rising edge is the event.
- modesel  in  2  0 up-from-0, 1 up-from-preset, 2 down-from-max, 3 down-from-preset.
- preset  in  4*NUM_DIGITS  BCD preset; any nibble >9 is clamped to 9 on load.
- an  out  NUM_DIGITS  active-low one-hot anode select.
- sseg  out  8  active-low segments, bit7 dp, bits6..0 gfedcba.
- done  out  1  high while in DONE.

## Operation
- Internal edge detect: each of stopstart and lap is registered and compared with its previous value. ev = in & ~prev.
- States: LOAD, ARMED, RUN, PAUSE, DONE.
- LOAD, one cycle: the count is loaded per modesel. Mode 0 loads 0. Modes 1 and 3 load the clamped preset. Mode 2 loads all 9s. The lap freeze is cleared. Next state is ARMED.
- ARMED: a stopstart edge moves to RUN.
- RUN: counting happens on count_tick with BCD carry/borrow across digits.
  - A stopstart edge moves to PAUSE, and there is no count that cycle.
  - Reaching the terminal value moves to DONE. For up-count the terminal value is all 9s; for down-count it is 0. The terminal value is displayed.
  - If the count loads already terminal (preset 0 in mode 3, or all 9s in mode 1), the first count_tick in RUN moves to DONE with no count.
- PAUSE: a stopstart edge returns to RUN.
- DONE: the count holds. A stopstart edge moves to LOAD.
- Any modesel change, detected against a registered copy, moves to LOAD from any state. This takes priority over all events.
- Lap: a lap edge in RUN or PAUSE toggles the freeze.
  - While frozen, the display shows the snapshot captured at the edge and counting continues.
  - Leaving to DONE or LOAD clears the freeze.
  - Lap edges in LOAD, ARMED or DONE are ignored.
- Display: the scan index increments on scan_tick and wraps from NUM_DIGITS-1 to 0.
  - an[idx]=0 and all other an bits are 1.
  - sseg comes from the displayed digit through bcd_to_sseg. The dp bit is 0 when idx==DP_POS.
  - A blanked digit drives sseg[6:0]=7'h7F.

## Timing
- Reset values: state LOAD, count 0, freeze 0, idx 0, an all 1s (blank), sseg 8'hFF, done 0, edge-detect registers 0.
  - LOAD runs on the first cycle after reset deasserts.
  - Reset mid-count discards the count.
- Event latency: an input edge at cycle n is detected at n+1, and the state changes at n+2.
- count_tick latency: a count_tick in RUN updates the count in the same edge it is sampled. The display reflects it the next cycle.
- The an and sseg outputs are registered, so they update one cycle after the idx change. an is never multi-hot.
- Simultaneous events in one cycle: modesel change beats stopstart, which beats count_tick, which beats lap. A lap coincident with stopstart still toggles the freeze.
- count_tick and scan_tick high simultaneously are independent.

## Structure
- Package stopwatch_pkg holds:
  - the state enum;
  - the mode constants MODE_UP0/UP_PRE/DN_MAX/DN_PRE;
  - SEG_BLANK (7'h7F) and the 0-9 segment constants.
- Sub-module bcd_to_sseg is a combinational 4-bit BCD to active-low 7-segment decoder. Codes >9 drive blank.
- The counter is a generate loop of per-digit BCD up/down cells with a carry/borrow chain.

## Test plan
- NUM_DIGITS=4, mode 0: reset, stopstart edge, then 125 count_ticks → count 0125. Scanning shows an 1110/1101/1011/0111 with digits 5,2,1,0, and dp on idx2.
- Mode 3, preset 16'h0003, run 3 ticks → 0000, done=1. Further ticks make no change. A stopstart edge → LOAD → 0003, done=0.
- Mode 1, preset 16'h9998, 2 ticks → 9999 and DONE. Preset 16'hA5F1 loads as 9591.
- In RUN, a stopstart edge in the same cycle as count_tick → PAUSE with no count. 50 ticks in PAUSE leave the count unchanged.
- Lap at count 0040, then 20 ticks → display 0040, internal 0060. A second lap → display 0060.
- Mode change 0→2 mid-run → LOAD → 9999 ARMED. LEAD_BLANK=1 with count 0007 shows three blank digits and "7". Reset mid-run returns an=all 1s and sseg=8'hFF.
